// File: rtl/pingpong_bank_ctrl_pkg.sv
// pingpong_bank_ctrl_pkg: bank-state encodings, bank-index width and the bank picker
// shared by the ping-pong buffer controller.
package pingpong_bank_ctrl_pkg;
    localparam int BANK_W = 1;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_t;

    // Chooses between two candidate banks; pref breaks the tie when both qualify.
    function automatic logic [BANK_W-1:0] pick(input logic b0, input logic b1, input logic pref);
        return (b0 && b1) ? pref : !b0;
    endfunction
endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// pingpong_bank_ctrl_if: writer/reader/RAM-side signals of the ping-pong controller.
// drop_cnt (and CW) exist only when PPBUF_STATUS_EN is defined.
interface pingpong_bank_ctrl_if #(
    parameter int AW = 8
`ifdef PPBUF_STATUS_EN
    , parameter int CW = 16
`endif
);
    logic          wr_valid;
    logic          rd_en;
    logic          rd_loop;
    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic          ram_re;
    logic [AW:0]   ram_raddr;
    logic          rd_valid;
    logic          rd_last;
    logic [3:0]    bank_state;
    logic          overrun;
`ifdef PPBUF_STATUS_EN
    logic [CW-1:0] drop_cnt;
`endif

    modport master (
        input  wr_valid, rd_en, rd_loop,
        output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, rd_last, bank_state, overrun
`ifdef PPBUF_STATUS_EN
        , output drop_cnt
`endif
    );

    modport slave (
        output wr_valid, rd_en, rd_loop,
        input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, rd_last, bank_state, overrun
`ifdef PPBUF_STATUS_EN
        , input drop_cnt
`endif
    );
endinterface

// File: rtl/pp_offset_cnt.sv
// pp_offset_cnt: AW-bit bank offset counter with clear, increment and terminal-count flag.
module pp_offset_cnt #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] cnt,
    output logic          tc
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + AW'(1);

    assign tc = &cnt;
endmodule

// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: two-bank circular capture buffer controller over one 2*2**AW-word RAM.
// Define PPBUF_STATUS_EN to add the saturating drop_cnt counter.
module pingpong_bank_ctrl
    import pingpong_bank_ctrl_pkg::*;
#(
    parameter int AW = 8
`ifdef PPBUF_STATUS_EN
    , parameter int CW = 16
`endif
) (
    input logic                 clk,
    input logic                 rst_n,
    pingpong_bank_ctrl_if.master bus
);
    bank_st_t            st [2];
    bank_st_t            st_nx [2];
    logic                wr_act, wr_act_nx, rd_act, rd_act_nx;
    logic [BANK_W-1:0]   wr_bank, wr_bank_nx, rd_bank, rd_bank_nx, last_fill, last_fill_nx;
    logic [BANK_W-1:0]   claim, w_bank, sel;
    logic [AW-1:0]       wcnt, rcnt;
    logic                wtc, rtc, e0, e1, f0, f1, we, ovr, start, rd_valid_q, rd_last_q;

    assign e0     = st[0] == EMPTY;
    assign e1     = st[1] == EMPTY;
    assign f0     = st[0] == FULL;
    assign f1     = st[1] == FULL;
    // last_fill resets to 1 so the first claim after reset lands on bank 0
    assign claim  = pick(e0, e1, ~last_fill);
    assign sel    = pick(f0, f1, ~last_fill);
    assign w_bank = wr_act ? wr_bank : claim;
    assign we     = rst_n && bus.wr_valid && (wr_act || e0 || e1);
    assign ovr    = rst_n && bus.wr_valid && !wr_act && !e0 && !e1;
    assign start  = !rd_act && bus.rd_en && (f0 || f1);

    pp_offset_cnt #(.AW(AW)) u_wcnt (
        .clk(clk), .rst_n(rst_n), .clr(we && wtc), .inc(we), .cnt(wcnt), .tc(wtc)
    );

    pp_offset_cnt #(.AW(AW)) u_rcnt (
        .clk(clk), .rst_n(rst_n), .clr(rd_act && rtc), .inc(rd_act), .cnt(rcnt), .tc(rtc)
    );

    always_comb begin
        st_nx        = st;
        wr_act_nx    = wr_act;
        wr_bank_nx   = wr_bank;
        rd_act_nx    = rd_act;
        rd_bank_nx   = rd_bank;
        last_fill_nx = last_fill;
        if (we) begin
            wr_bank_nx     = w_bank;
            wr_act_nx      = !wtc;
            st_nx[w_bank]  = wtc ? FULL : FILLING;
            last_fill_nx   = wtc ? w_bank : last_fill;
        end
        if (start) begin
            rd_act_nx  = 1'b1;
            rd_bank_nx = sel;
            st_nx[sel] = DRAINING;
        end
        // Looping keeps a lone bank available for replay; a newer full bank takes priority
        if (rd_act && rtc) begin
            rd_act_nx      = 1'b0;
            st_nx[rd_bank] = (bus.rd_loop && st[~rd_bank] != FULL) ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st         <= '{EMPTY, EMPTY};
            wr_act     <= 1'b0;
            wr_bank    <= '0;
            rd_act     <= 1'b0;
            rd_bank    <= '0;
            last_fill  <= '1;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            st         <= st_nx;
            wr_act     <= wr_act_nx;
            wr_bank    <= wr_bank_nx;
            rd_act     <= rd_act_nx;
            rd_bank    <= rd_bank_nx;
            last_fill  <= last_fill_nx;
            rd_valid_q <= rd_act;
            rd_last_q  <= rd_act && rtc;
        end

    assign bus.ram_we     = we;
    assign bus.ram_waddr  = {w_bank, wcnt};
    assign bus.ram_re     = rd_act;
    assign bus.ram_raddr  = {rd_bank, rcnt};
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_last    = rd_last_q;
    assign bus.bank_state = {st[1], st[0]};
    assign bus.overrun    = ovr;

`ifdef PPBUF_STATUS_EN
    logic [CW-1:0] dc;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dc <= '0;
        else if (ovr && !(&dc)) dc <= dc + CW'(1);

    assign bus.drop_cnt = dc;
`endif
endmodule
